// File: rtl/fft_psd_avg_pkg.sv
// rtl/fft_psd_avg_pkg.sv - shared sample type, width helpers and state enum for the PSD averager
package fft_psd_avg_pkg;

    localparam int FPT_W = 16;

    typedef logic signed [FPT_W-1:0] fpt;

    typedef enum logic {
        PSD_IDLE = 1'b0,
        PSD_RUN  = 1'b1
    } psd_state_t;

    function automatic int pwr_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int acc_w(input int w, input int log_m);
        return pwr_w(w) + log_m;
    endfunction

endpackage

// File: rtl/fft_psd_avg_cplx_mag2.sv
// rtl/fft_psd_avg_cplx_mag2.sv - combinational |X|^2 of one complex sample, exact and unsigned
module cplx_mag2
    import fft_psd_avg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2*W-1:0]     in_data,
    output logic [pwr_w(W)-1:0] power
);

    logic signed [2*W-1:0] re_x;
    logic signed [2*W-1:0] im_x;
    logic signed [2*W-1:0] sq_re;
    logic signed [2*W-1:0] sq_im;

    // Sign-extend first so the squares are formed at full width; each fits as a positive 2W value.
    always_comb begin
        re_x  = $signed({{W{in_data[2*W-1]}}, in_data[2*W-1:W]});
        im_x  = $signed({{W{in_data[W-1]}}, in_data[W-1:0]});
        sq_re = re_x * re_x;
        sq_im = im_x * im_x;
        power = {1'b0, sq_re} + {1'b0, sq_im};
    end

endmodule

// File: rtl/fft_psd_avg.sv
// rtl/fft_psd_avg.sv - per-bin power accumulator averaging 2^LOG_M FFT frames
// Optional round-half-up before the divide: define PSD_ROUND_EN.
module fft_psd_avg
    import fft_psd_avg_pkg::*;
#(
    parameter int N     = 3,
    parameter int W     = 16,
    parameter int LOG_M = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [2*W-1:0]      in_data,
    output logic                out_valid,
    output logic                out_start,
    output logic [N-1:0]        out_bin,
    output logic [2*W:0]        out_power,
    output logic                frame_err
);

    localparam int PWR_W = pwr_w(W);
    localparam int ACC_W = acc_w(W, LOG_M);
    localparam int BINS  = 1 << N;
    localparam int FC_W  = (LOG_M > 0) ? LOG_M : 1;
    localparam logic [N-1:0]    LAST_BIN   = N'(BINS - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'((1 << LOG_M) - 1);
`ifdef PSD_ROUND_EN
    localparam int RND_I = (LOG_M > 0) ? (1 << ((LOG_M > 0) ? (LOG_M - 1) : 0)) : 0;
`else
    localparam int RND_I = 0;
`endif
    localparam logic [ACC_W:0] RND = (ACC_W + 1)'(RND_I);

    psd_state_t state, state_nxt;

    logic [N-1:0]     bcnt;
    logic [FC_W-1:0]  fcnt;
    logic [ACC_W-1:0] acc [BINS];
    logic [PWR_W-1:0] p;

    logic             sample;
    logic             restart;
    logic [N-1:0]     bin;
    logic [FC_W-1:0]  cur_fcnt;
    logic             final_frame;
    logic             last_bin;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   sum_rnd;
    logic [PWR_W-1:0] avg;

    cplx_mag2 #(.W(W)) u_mag2 (
        .in_data (in_data),
        .power   (p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PSD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // bcnt holds the index of the bin arriving in the current RUN cycle (1..2^N-1).
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        restart   = 1'b0;
        bin       = '0;
        case (state)
            PSD_IDLE: begin
                if (frame_start) begin
                    sample    = 1'b1;
                    state_nxt = PSD_RUN;
                end
            end
            PSD_RUN: begin
                sample = 1'b1;
                if (frame_start && bcnt != LAST_BIN) begin
                    restart = 1'b1;
                end else begin
                    bin = bcnt;
                    if (bcnt == LAST_BIN) begin
                        state_nxt = PSD_IDLE;
                    end
                end
            end
            default: state_nxt = PSD_IDLE;
        endcase
    end

    // A restarted frame sees an all-zero accumulator and frame count 0.
    always_comb begin
        cur_fcnt    = restart ? '0 : fcnt;
        final_frame = (cur_fcnt == LAST_FRAME);
        last_bin    = (bin == LAST_BIN);
        sum         = (restart ? '0 : {1'b0, acc[bin]}) + (ACC_W + 1)'(p);
        sum_rnd     = sum + RND;
        avg         = PWR_W'(sum_rnd >> LOG_M);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt      <= '0;
            fcnt      <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_bin   <= '0;
            out_power <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < BINS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            frame_err <= restart;
            out_valid <= sample && final_frame;
            out_start <= sample && final_frame && (bin == '0);
            if (restart) begin
                for (int i = 0; i < BINS; i++) begin
                    acc[i] <= '0;
                end
            end
            if (sample) begin
                bcnt <= bin + N'(1);
                if (final_frame) begin
                    acc[bin]  <= '0;
                    out_bin   <= bin;
                    out_power <= avg;
                end else begin
                    acc[bin]  <= sum[ACC_W-1:0];
                end
                if (last_bin) begin
                    fcnt <= final_frame ? '0 : cur_fcnt + FC_W'(1);
                end else begin
                    fcnt <= cur_fcnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_psd_avg.sv
// tb/tb_fft_psd_avg.sv - bench driving LOG_M=0 and LOG_M=2 averagers against a frame-level power model
module tb_fft_psd_avg;

`ifdef PSD_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] in_data = '0;

    logic        o_valid [2];
    logic        o_start [2];
    logic        o_err   [2];
    logic [2:0]  o_bin   [2];
    logic [32:0] o_power [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: pos = next expected bin of an open frame, -1 when no frame is open
    int     m_pos    [2];
    int     m_frames [2];
    longint m_sum    [2][8];
    bit     e_valid  [2];
    bit     e_start  [2];
    bit     e_err    [2];
    longint e_bin    [2];
    longint e_power  [2];

    int fr_re [8];
    int fr_im [8];

    always #5 clk = ~clk;

    fft_psd_avg #(.N(3), .W(16), .LOG_M(0)) dut0 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .in_data(in_data),
        .out_valid(o_valid[0]), .out_start(o_start[0]), .out_bin(o_bin[0]),
        .out_power(o_power[0]), .frame_err(o_err[0])
    );

    fft_psd_avg #(.N(3), .W(16), .LOG_M(2)) dut2 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .in_data(in_data),
        .out_valid(o_valid[1]), .out_start(o_start[1]), .out_bin(o_bin[1]),
        .out_power(o_power[1]), .frame_err(o_err[1])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit fs, input int re, input int im);
        for (int i = 0; i < 2; i++) begin
            int     lm;
            int     mfr;
            int     b;
            longint p;
            longint total;
            longint rnd;
            lm  = (i == 0) ? 0 : 2;
            mfr = 1 << lm;
            if (rst) begin
                m_pos[i] = -1;
                m_frames[i] = 0;
                for (int k = 0; k < 8; k++) m_sum[i][k] = 0;
                e_valid[i] = 0; e_start[i] = 0; e_err[i] = 0; e_bin[i] = 0; e_power[i] = 0;
            end else begin
                p = longint'(re) * re + longint'(im) * im;
                e_valid[i] = 0; e_start[i] = 0; e_err[i] = 0;
                b = -1;
                if (fs) begin
                    if (m_pos[i] > 0) begin
                        e_err[i] = 1;
                        m_frames[i] = 0;
                        for (int k = 0; k < 8; k++) m_sum[i][k] = 0;
                    end
                    b = 0;
                end else if (m_pos[i] > 0) begin
                    b = m_pos[i];
                end
                if (b >= 0) begin
                    if (m_frames[i] == mfr - 1) begin
                        total = m_sum[i][b] + p;
                        rnd = (ROUND && lm > 0) ? (longint'(1) << (lm - 1)) : 0;
                        e_power[i] = (total + rnd) >> lm;
                        e_bin[i] = b;
                        e_valid[i] = 1;
                        e_start[i] = (b == 0);
                        m_sum[i][b] = 0;
                    end else begin
                        m_sum[i][b] += p;
                    end
                    if (b == 7) begin
                        m_frames[i] = (m_frames[i] + 1) % mfr;
                        m_pos[i] = -1;
                    end else begin
                        m_pos[i] = b + 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit fs, input int re, input int im);
        @(negedge clk);
        reset = rst;
        frame_start = fs;
        in_data = {re[15:0], im[15:0]};
        model_step(rst, fs, re, im);
        chk_en = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_frame(input int re, input int im);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = re;
            fr_im[k] = im;
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < 8; k++) step(1'b0, k == 0, fr_re[k], fr_im[k]);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("out_valid[m%0d]", i), longint'(o_valid[i]), longint'(e_valid[i]));
                chk($sformatf("out_start[m%0d]", i), longint'(o_start[i]), longint'(e_start[i]));
                chk($sformatf("frame_err[m%0d]", i), longint'(o_err[i]), longint'(e_err[i]));
                chk($sformatf("out_bin[m%0d]", i), longint'(o_bin[i]), e_bin[i]);
                chk($sformatf("out_power[m%0d]", i), longint'(o_power[i]), e_power[i]);
            end
        end
    end

    initial begin
        // reset state
        do_reset();
        settle();
        chk("reset out_valid", longint'(o_valid[1]), 0);
        chk("reset out_power", longint'(o_power[1]), 0);

        // LOG_M=0: bin k = (k, 0) gives k^2 one cycle later
        for (int k = 0; k < 8; k++) begin
            step(1'b0, k == 0, k, 0);
            settle();
            chk($sformatf("pass bin%0d power", k), longint'(o_power[0]), longint'(k * k));
            chk($sformatf("pass bin%0d start", k), longint'(o_start[0]), longint'(k == 0));
        end
        step(1'b0, 1'b0, 0, 0);
        settle();
        chk("pass valid drops", longint'(o_valid[0]), 0);

        // LOG_M=2: bin 3 = (3,-4) over back-to-back frames
        do_reset();
        set_frame(0, 0);
        fr_re[3] = 3;
        fr_im[3] = -4;
        for (int f = 0; f < 3; f++) send_frame();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, k == 0, fr_re[k], fr_im[k]);
            settle();
            chk($sformatf("avg bin%0d", k), longint'(o_power[1]), (k == 3) ? 25 : 0);
            chk($sformatf("avg valid%0d", k), longint'(o_valid[1]), 1);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, k == 0, fr_re[k], fr_im[k]);
            settle();
            chk("fifth frame silent", longint'(o_valid[1]), 0);
        end
        for (int f = 0; f < 3; f++) send_frame();
        step(1'b0, 1'b0, 0, 0);

        // rounding: bin 0 powers 1,1,1,0 then 1,1,0,0
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int f = 0; f < 4; f++) begin
                set_frame(0, 0);
                fr_re[0] = (f < 3 - r) ? 1 : 0;
                send_frame();
                if (f == 3) begin
                    chk($sformatf("round case%0d", r), longint'(o_power[1]), 0);
                end
            end
            // bin 0 result was registered 8 cycles ago; re-check via the burst on a repeat
        end
        do_reset();
        for (int f = 0; f < 4; f++) begin
            step(1'b0, 1'b1, (f < 3) ? 1 : 0, 0);
            settle();
            if (f == 3) chk("round 3/4", longint'(o_power[1]), ROUND ? 1 : 0);
            for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 0, 0);
        end
        for (int f = 0; f < 4; f++) begin
            step(1'b0, 1'b1, (f < 2) ? 1 : 0, 0);
            settle();
            if (f == 3) chk("round 2/4", longint'(o_power[1]), ROUND ? 1 : 0);
            for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 0, 0);
        end

        // extremes: no wrap at 2^31 per frame
        do_reset();
        set_frame(-32768, -32768);
        for (int f = 0; f < 3; f++) send_frame();
        step(1'b0, 1'b1, -32768, -32768);
        settle();
        chk("extreme avg", longint'(o_power[1]), longint'(1) << 31);
        chk("extreme pass", longint'(o_power[0]), longint'(1) << 31);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b0, -32768, -32768);

        // early restart at bin 5 of frame 1
        do_reset();
        set_frame(2, 0);
        send_frame();
        for (int k = 0; k < 5; k++) step(1'b0, k == 0, 2, 0);
        step(1'b0, 1'b1, 1, 0);
        settle();
        chk("restart err m2", longint'(o_err[1]), 1);
        chk("restart err m0", longint'(o_err[0]), 1);
        chk("restart pass p", longint'(o_power[0]), 1);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 1, 0);
        settle();
        chk("restart no out", longint'(o_valid[1]), 0);
        set_frame(1, 0);
        send_frame();
        send_frame();
        step(1'b0, 1'b1, 1, 0);
        settle();
        chk("restart avg valid", longint'(o_valid[1]), 1);
        chk("restart avg power", longint'(o_power[1]), 1);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 1, 0);

        // reset mid-burst at bin 4
        do_reset();
        set_frame(2, 0);
        for (int f = 0; f < 3; f++) send_frame();
        for (int k = 0; k < 4; k++) step(1'b0, k == 0, 2, 0);
        settle();
        chk("burst before reset", longint'(o_power[1]), 4);
        step(1'b1, 1'b0, 2, 0);
        settle();
        chk("reset burst valid", longint'(o_valid[1]), 0);
        chk("reset burst bin", longint'(o_bin[1]), 0);
        chk("reset burst power", longint'(o_power[1]), 0);
        step(1'b0, 1'b0, 0, 0);
        set_frame(1, 0);
        for (int f = 0; f < 3; f++) send_frame();
        step(1'b0, 1'b1, 1, 0);
        settle();
        chk("post reset avg", longint'(o_power[1]), 1);
        chk("post reset start", longint'(o_start[1]), 1);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 1, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
